// File: rtl/uart_tx_fifo_if.sv
// Byte-stream interface between the RAM-to-UART read controller and the
// buffered UART transmitter; width of fifo_level follows FIFO_DEPTH.
interface uart_tx_fifo_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             start;
  logic [7:0]       data_in;
  logic             ready;
  logic             TX;
  logic             tx_busy;
  logic [LVL_W-1:0] fifo_level;
  logic             overflow;

  modport master (
    output start,
    output data_in,
    input  ready,
    input  TX,
    input  tx_busy,
    input  fifo_level,
    input  overflow
  );

  modport slave (
    input  start,
    input  data_in,
    output ready,
    output TX,
    output tx_busy,
    output fifo_level,
    output overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding an LSB-first serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1, 11-bit frame).
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_fifo_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [7:0]       head;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic             bit_done;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == FULL_LVL);
  assign head       = fifo_mem[rd_ptr_q];
  assign bit_done   = (bit_cnt_q == LAST_CNT);

  // A full FIFO refuses the write even if a pop frees a slot this cycle.
  assign push = bus.start && !fifo_full;

  // Head is taken either from idle or on the last stop-bit cycle, so
  // back-to-back frames leave no idle gap on the line.
  assign pop = !fifo_empty &&
               ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_done));

  // ---------------------------------------------------------------------
  // FIFO bookkeeping
  // ---------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    if (bus.start && fifo_full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.data_in;
  end

  // ---------------------------------------------------------------------
  // Frame FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Frame FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pop) state_d = S_START;
      end
      S_START: begin
        if (bit_done) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_done && (bit_idx_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_done) state_d = pop ? S_START : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Frame FSM: outputs and bit timing
  // ---------------------------------------------------------------------
  always_comb begin
    tx_d      = 1'b1;
    busy_d    = (state_q != S_IDLE) || !fifo_empty;
    bit_cnt_d = (state_q == S_IDLE || bit_done) ? '0 : bit_cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_q;
`endif
      default:  tx_d = 1'b1;
    endcase

    if (state_q == S_START) bit_idx_d = 3'd0;
    if (state_q == S_DATA && bit_done) begin
      bit_idx_d = bit_idx_q + 3'd1;
      shift_d   = {1'b0, shift_q[7:1]};
    end

    // Parity is captured at load time because the shifter consumes the byte.
    if (pop) begin
      shift_d  = head;
`ifdef UART_TX_PARITY_EN
      parity_d = ^head;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Control registers (TX and busy lag the FSM by one cycle together)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      bit_cnt_q <= '0;
      bit_idx_q <= 3'd0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    shift_q  <= shift_d;
`ifdef UART_TX_PARITY_EN
    parity_q <= parity_d;
`endif
  end

  assign bus.ready      = !fifo_full;
  assign bus.TX         = tx_q;
  assign bus.tx_busy    = busy_q;
  assign bus.fifo_level = level_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed steps plus random traffic, every cycle
// compared against a timing-level model of the FIFO and serial frames.
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FL = NBITS * CPB;

  logic clk = 1'b0;
  logic rst_n;

  uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  int         e     = 0;
  logic [7:0] mq[$];
  int         free_at;
  int         pop_e;
  logic [7:0] cur_b;
  bit         movf;

  // Expected line level for bit slot idx of a frame carrying byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s at edge %0d: got %0h want %0h", tag, e, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    free_at = 0;
    pop_e   = -100000;
    cur_b   = 8'h00;
    movf    = 1'b0;
  endtask

  // One clock: drive inputs, advance the model by one edge, compare outputs.
  task automatic cycle(input bit s, input logic [7:0] d);
    int lvl_b;
    int k;
    bit act;
    bus.start   = s;
    bus.data_in = d;
    @(posedge clk);
    e++;
    lvl_b = mq.size();
    if (lvl_b != 0 && e >= free_at) begin
      cur_b   = mq.pop_front();
      pop_e   = e;
      free_at = e + FL;
    end
    if (s) begin
      if (lvl_b != DEPTH) mq.push_back(d);
      else movf = 1'b1;
    end
    #1;
    k   = e - pop_e - 1;
    act = (k >= 0) && (k < FL);
    chk("fifo_level", 32'(bus.fifo_level), 32'(mq.size()));
    chk("ready", 32'(bus.ready), 32'(mq.size() != DEPTH));
    chk("overflow", 32'(bus.overflow), 32'(movf));
    chk("TX", 32'(bus.TX), 32'(act ? exp_bit(cur_b, k / CPB) : 1'b1));
    chk("tx_busy", 32'(bus.tx_busy), 32'(act || (lvl_b != 0)));
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    repeat (2) cycle(1'b0, 8'h00);
    while (bus.tx_busy !== 1'b0 && n < budget) begin
      cycle(1'b0, 8'h00);
      n++;
    end
    chk(tag, 32'(bus.tx_busy), 32'd0);
  endtask

  initial begin
    int t_push;
    int t_low;
    int n;
    bus.start   = 1'b0;
    bus.data_in = 8'h00;
    rst_n       = 1'b0;
    model_reset();

    // Reset values
    #22;
    chk("rst_TX", 32'(bus.TX), 32'd1);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_level", 32'(bus.fifo_level), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_busy", 32'(bus.tx_busy), 32'd0);
    rst_n = 1'b1;
    repeat (3) cycle(1'b0, 8'h00);

    // Single byte on an idle line
    cycle(1'b1, 8'hA5);
    t_push = e;
    n = 0;
    while (bus.TX !== 1'b0 && n < 10) begin cycle(1'b0, 8'h00); n++; end
    chk("tx_fall_latency", 32'(e - t_push), 32'd2);
    t_low = e;
    n = 0;
    while (bus.tx_busy !== 1'b0 && n < 200) begin cycle(1'b0, 8'h00); n++; end
    chk("single_busy_span", 32'(e - t_low), 32'(FL));
    repeat (3) cycle(1'b0, 8'h00);

    // Burst of 16 consecutive pushes
    t_push = e + 1;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, i[7:0]);
      chk("burst_ready", 32'(bus.ready), 32'd1);
    end
    n = 0;
    while (bus.tx_busy !== 1'b0 && n < 2000) begin cycle(1'b0, 8'h00); n++; end
    chk("burst_span", 32'(e - (t_push + 2)), 32'(16 * FL));
    repeat (2) cycle(1'b0, 8'h00);

    // Overflow while the line is busy
    cycle(1'b1, 8'h5A);
    repeat (3) cycle(1'b0, 8'h00);
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b1, 8'($urandom));
    chk("ovf_level", 32'(bus.fifo_level), 32'(DEPTH));
    chk("ovf_ready", 32'(bus.ready), 32'd0);
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    drain("ovf_drain", (DEPTH + 2) * FL + 50);
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);

    // Push coinciding with the pop on the stop-bit terminal cycle
    cycle(1'b1, 8'h3C);
    cycle(1'b1, 8'hC3);
    chk("pushpop_level", 32'(bus.fifo_level), 32'd1);
    repeat (FL - 1) cycle(1'b0, 8'h00);
    cycle(1'b1, 8'h96);
    chk("stop_pushpop_level", 32'(bus.fifo_level), 32'd1);
    drain("pushpop_drain", 4 * FL);

    // Parity-sensitive bytes (plain 8N1 in the default build)
    cycle(1'b1, 8'h07);
    cycle(1'b1, 8'h03);
    drain("parity_drain", 3 * FL);

    // Asynchronous reset in the middle of a frame
    cycle(1'b1, 8'h00);
    cycle(1'b1, 8'h11);
    cycle(1'b1, 8'h22);
    repeat (7) cycle(1'b0, 8'h00);
    chk("pre_rst_TX_low", 32'(bus.TX), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_TX", 32'(bus.TX), 32'd1);
    chk("mid_rst_level", 32'(bus.fifo_level), 32'd0);
    chk("mid_rst_ready", 32'(bus.ready), 32'd1);
    chk("mid_rst_overflow", 32'(bus.overflow), 32'd0);
    chk("mid_rst_busy", 32'(bus.tx_busy), 32'd0);
    model_reset();
    #3;
    rst_n = 1'b1;
    repeat (4) cycle(1'b0, 8'h00);

    // Random traffic: sparse phase, then a dense phase that overruns
    for (int i = 0; i < 600; i++)
      cycle(($urandom_range(0, 39) == 0), 8'($urandom));
    for (int i = 0; i < 300; i++)
      cycle(($urandom_range(0, 3) == 0), 8'($urandom));
    drain("random_drain", (DEPTH + 2) * FL + 50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
